// File: rtl/up_fetch.sv
// up_fetch: instruction fetch stage with prefetch FIFO feeding the up core decode stage.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   mem_req_out/addr_out    program-memory read request and address (held until ack)
//   mem_ack_in/data_in      memory acknowledge with same-cycle instruction word
//   instr_valid/instr/pc    FIFO head towards decode; instr_ready_in pops it
//   branch_in/addr_in       one-cycle redirect strobe: flush FIFO and refetch at target
//   halt_in                 level; blocks new requests, FIFO keeps draining
//   fifo_count_out          current FIFO occupancy
module up_fetch #(
   parameter int ADDR_W = 8,
   parameter int INSTR_W = 16,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   output logic                       mem_req_out,
   output logic [ADDR_W-1:0]          mem_addr_out,
   input  logic                       mem_ack_in,
   input  logic [INSTR_W-1:0]         mem_data_in,
   output logic                       instr_valid_out,
   output logic [INSTR_W-1:0]         instr_out,
   output logic [ADDR_W-1:0]          instr_pc_out,
   input  logic                       instr_ready_in,
   input  logic                       branch_in,
   input  logic [ADDR_W-1:0]          branch_addr_in,
   input  logic                       halt_in,
   output logic [$clog2(DEPTH):0]     fifo_count_out
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DISC = 2'd2;
   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
   logic [INSTR_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0]  tag_q [DEPTH];
   logic               req, ack, push, pop;
   always_comb begin
      req = state_q != S_IDLE;
      ack = req & mem_ack_in;
      // DISCARD and branch-with-ack both drop the returning word
      push = ack & (state_q == S_REQ) & ~branch_in;
      pop = (count_q != '0) & instr_ready_in;
      count_d = branch_in ? '0 : count_q + CW'(push) - CW'(pop);
      rd_d = branch_in ? '0 : rd_q + PW'(pop);
      wr_d = branch_in ? '0 : wr_q + PW'(push);
      pc_d = branch_in ? branch_addr_in : push ? pc_q + 1'b1 : pc_q;
      // address frozen while a request waits for its ack, otherwise tracks next fetch pc
      addr_d = (req & ~mem_ack_in) ? addr_q : pc_d;
      // count_d < FULL leaves room for the word the next request will return
      state_d = (state_q == S_IDLE) ? ((~halt_in & ~branch_in & (count_q < FULL)) ? S_REQ : S_IDLE)
              : ack ? ((~halt_in & (count_d < FULL)) ? S_REQ : S_IDLE)
              : (branch_in | (state_q == S_DISC)) ? S_DISC : S_REQ;
   end
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         pc_q <= RESET_PC;
         addr_q <= '0;
         count_q <= '0;
         rd_q <= '0;
         wr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         addr_q <= addr_d;
         count_q <= count_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         if (push) begin
            data_q[wr_q] <= mem_data_in;
            tag_q[wr_q] <= pc_q;
         end
      end
   end
   assign mem_req_out = req;
   assign mem_addr_out = addr_q;
   assign instr_valid_out = count_q != '0;
   assign instr_out = data_q[rd_q];
   assign instr_pc_out = tag_q[rd_q];
   assign fifo_count_out = count_q;
endmodule

// File: tb/tb_up_fetch.sv
// tb_up_fetch: randomized bench for up_fetch against a transaction-level queue model.
module tb_up_fetch;
   localparam int DEPTH = 4;
   logic clk_in = 0;
   always #5 clk_in = ~clk_in;
   logic rst_in, mem_req_out, mem_ack_in, instr_valid_out, instr_ready_in, branch_in, halt_in;
   logic [7:0] mem_addr_out, instr_pc_out, branch_addr_in;
   logic [15:0] mem_data_in, instr_out;
   logic [2:0] fifo_count_out;
   logic w_rst, w_req, w_ack, w_valid;
   logic [7:0] w_addr, w_pc;
   logic [15:0] w_data, w_instr;
   logic [2:0] w_count;
   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {a ^ 8'hA5, ~a};
   endfunction
   assign mem_data_in = mem_ack_in ? mem_word(mem_addr_out) : '0;
   assign w_data = w_ack ? mem_word(w_addr) : '0;
   up_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
      .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
      .instr_valid_out(instr_valid_out), .instr_out(instr_out), .instr_pc_out(instr_pc_out),
      .instr_ready_in(instr_ready_in), .branch_in(branch_in), .branch_addr_in(branch_addr_in),
      .halt_in(halt_in), .fifo_count_out(fifo_count_out));
   up_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
      .clk_in(clk_in), .rst_in(w_rst),
      .mem_req_out(w_req), .mem_addr_out(w_addr),
      .mem_ack_in(w_ack), .mem_data_in(w_data),
      .instr_valid_out(w_valid), .instr_out(w_instr), .instr_pc_out(w_pc),
      .instr_ready_in(1'b1), .branch_in(1'b0), .branch_addr_in(8'h00),
      .halt_in(1'b0), .fifo_count_out(w_count));
   int n_vec = 0, n_err = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   typedef struct {logic [15:0] instr; logic [7:0] pc;} ent_t;
   ent_t q[$];
   logic [7:0] mpc = 8'h00, hold_addr;
   logic stale = 0, hold = 0, exp_req = 0, run = 0;
   // Model: queue of expected FIFO contents, next fetch PC, and whether the
   // outstanding request was orphaned by a branch.
   always @(negedge clk_in) if (run) begin
      logic ack, pop;
      int size_pre;
      check("req", 32'(mem_req_out), 32'(exp_req));
      check("valid", 32'(instr_valid_out), 32'(q.size() != 0));
      check("count", 32'(fifo_count_out), 32'(q.size()));
      if (q.size() != 0) begin
         check("instr", 32'(instr_out), 32'(q[0].instr));
         check("pc", 32'(instr_pc_out), 32'(q[0].pc));
      end
      if (hold) check("addr_hold", 32'(mem_addr_out), 32'(hold_addr));
      size_pre = q.size();
      ack = mem_req_out & mem_ack_in;
      pop = (q.size() != 0) & instr_ready_in;
      if (ack && !stale && !branch_in) begin
         check("addr", 32'(mem_addr_out), 32'(mpc));
         q.push_back('{mem_word(mpc), mpc});
         mpc++;
      end
      if (ack) stale = 0;
      if (pop) void'(q.pop_front());
      if (branch_in) begin
         q.delete();
         mpc = branch_addr_in;
         if (mem_req_out && !ack) stale = 1;
      end
      exp_req = !mem_req_out ? (!halt_in && !branch_in && size_pre < DEPTH)
              : !mem_ack_in ? 1'b1 : (!halt_in && q.size() < DEPTH);
      hold = mem_req_out & !mem_ack_in;
      hold_addr = mem_addr_out;
   end
   task automatic run_phase(input int n, input int rdy_pct, input int ack_pct, input int br_pct, input int halt_pct);
      for (int c = 0; c < n; c++) begin
         @(posedge clk_in);
         #1;
         instr_ready_in = $urandom_range(99) < rdy_pct;
         mem_ack_in = mem_req_out && ($urandom_range(99) < ack_pct);
         branch_in = $urandom_range(99) < br_pct;
         branch_addr_in = ($urandom_range(3) == 0) ? 8'hFD : 8'($urandom);
         if ($urandom_range(99) < halt_pct) halt_in = !halt_in;
      end
      @(posedge clk_in);
      #1;
      halt_in = 0;
      branch_in = 0;
      mem_ack_in = 0;
   endtask
   initial begin
      int k;
      logic [7:0] ew;
      rst_in = 0; mem_ack_in = 0; instr_ready_in = 0; branch_in = 0; branch_addr_in = 0; halt_in = 0;
      w_rst = 0; w_ack = 0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_req", 32'(mem_req_out), 0);
      check("rst_addr", 32'(mem_addr_out), 0);
      check("rst_valid", 32'(instr_valid_out), 0);
      check("rst_instr", 32'(instr_out), 0);
      check("rst_pc", 32'(instr_pc_out), 0);
      check("rst_count", 32'(fifo_count_out), 0);
      rst_in = 1;
      run = 1;
      run_phase(20, 100, 100, 0, 0);
      run_phase(30, 0, 100, 0, 0);
      run_phase(600, 80, 70, 4, 4);
      run_phase(600, 25, 50, 3, 6);
      run_phase(600, 95, 30, 8, 2);
      w_rst = 1;
      k = 0;
      ew = 8'hFE;
      for (int c = 0; c < 20 && k < 3; c++) begin
         @(posedge clk_in);
         #1;
         w_ack = w_req;
         if (w_req) begin
            check("wrap_addr", 32'(w_addr), 32'(ew));
            ew++;
            k++;
         end
      end
      check("wrap_acks", 32'(k), 3);
      @(posedge clk_in);
      #1;
      w_ack = 0;
      check("wrap_req_held", 32'(w_req), 1);
      #3 w_rst = 0;
      #1;
      check("async_req", 32'(w_req), 0);
      check("async_addr", 32'(w_addr), 0);
      check("async_valid", 32'(w_valid), 0);
      check("async_instr", 32'(w_instr), 0);
      check("async_pc", 32'(w_pc), 0);
      check("async_count", 32'(w_count), 0);
      @(posedge clk_in);
      run = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/up_fetch.md
Name: up_fetch

Overview:
- Instruction fetch stage directly upstream of the `up` processor core.
- Reads program memory through a req/ack handshake and buffers instructions in a small prefetch FIFO, each tagged with its PC.
- Presents instructions to the core's decode stage over a valid/ready interface.
- Handles branch redirects, FIFO flush and halt on the core's request.

Parameters:
- ADDR_W, 8, program-counter and memory address width
- INSTR_W, 16, instruction word width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, fetch address after reset

Ports:
- clk_in  input  1  single system clock, rising edge
- rst_in  input  1  asynchronous active-low reset
- mem_req_out  output  1  program-memory read request
- mem_addr_out  output  ADDR_W  read address, stable while mem_req_out=1
- mem_ack_in  input  1  memory acknowledge; mem_data_in valid in the same cycle
- mem_data_in  input  INSTR_W  instruction word returned
- instr_valid_out  output  1  FIFO head holds a valid instruction
- instr_out  output  INSTR_W  head instruction
- instr_pc_out  output  ADDR_W  PC of head instruction
- instr_ready_in  input  1  core accepts head this cycle
- branch_in  input  1  one-cycle redirect strobe from core
- branch_addr_in  input  ADDR_W  redirect target
- halt_in  input  1  level; suppresses new memory requests
- fifo_count_out  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_in=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE.
  - All outputs 0: mem_req_out=0, mem_addr_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, fifo_count_out=0.
  - Reset asserted mid-transaction abandons the request immediately.
- FSM states: IDLE, REQ, DISCARD.
- IDLE → REQ when halt_in=0, branch_in=0 and (count + pending) < DEPTH.
  - On entry: mem_req_out=1, mem_addr_out=fetch_pc.
- REQ:
  - mem_req_out and mem_addr_out are held until mem_ack_in=1.
  - On ack: write {mem_data_in, fetch_pc} into the FIFO; fetch_pc ← fetch_pc+1, wrapping modulo 2^ADDR_W.
  - After ack: go back to IDLE, or stay in REQ with the new address if space remains and halt_in=0 (back-to-back, one request per ack).
  - At most one outstanding request at any time.
- Branch (branch_in=1), any state:
  - FIFO flushed (count=0, instr_valid_out=0 next cycle); fetch_pc ← branch_addr_in.
  - If in REQ without an ack in that cycle: mem_req_out stays high until the ack (no address change mid-request), state → DISCARD.
  - DISCARD: the returning word is dropped; then → REQ at the branch target.
  - Branch in the same cycle as an ack: the acked word is discarded; → REQ at the target next cycle.
  - Branch in the same cycle as instr_valid_out & instr_ready_in: the pop counts as consumed; the flush still applies.
- Output handshake:
  - Transfer occurs when instr_valid_out & instr_ready_in.
  - Head data is registered FIFO output and stays stable while valid & !ready.
  - Latency: ack in cycle N → instr_valid_out=1 in cycle N+1 when the FIFO was empty.
- Full/empty:
  - No request is issued when count + pending = DEPTH.
  - Simultaneous push and pop keeps count unchanged, including when full.
  - Pop when empty is ignored.
- Halt:
  - No new request is started; an outstanding request completes and is stored.
  - The FIFO keeps draining to the core.
  - Deasserting halt resumes at fetch_pc.
- PC wrap: fetch at address 2^ADDR_W−1 is followed by a fetch at 0 with no error.

Test Plan:
- Reset then release, memory acks every cycle, ready=1 → addresses 0,1,2,3…; instr_pc_out follows one cycle after each ack; fifo_count_out stays ≤1.
- ready=0 with DEPTH=4 → exactly 4 acks accepted; mem_req_out=0 afterwards; fifo_count_out=4. Raise ready → heads popped in order with PCs 0..3; fetching resumes at 4.
- Memory ack delayed 3 cycles at addr 2, branch_in with target 0x40 in the wait → mem_addr_out held at 2 until ack; that word is not seen at the output; next request is 0x40; first valid instruction has instr_pc_out=0x40.
- Branch in the same cycle as an ack and a pop → FIFO empty next cycle; the acked word is dropped; next request is the branch target.
- halt_in=1 while a request is outstanding → request completes and is stored; no further mem_req_out while halted; release → fetch continues at the next PC.
- Start at RESET_PC=0xFE → fetch addresses 0xFE, 0xFF, 0x00. Assert rst_in=0 mid-request → mem_req_out falls without waiting for a clock edge; all outputs 0.
